data_bus_mmio: RTL and testbench
================================

DATA_BUS_MMIO -- requirements
Module: data_bus_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, meaning data RAM depth in 32-bit words.
REQ-002 SHALL have parameter TX_DEPTH, default 8, meaning TX FIFO entries (power of two).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port data_memory_addr, input, 32, the core byte address.
REQ-007 SHALL have port data_memory_wd, input, 32, the core write data.
REQ-008 SHALL have port data_memory_we, input, 1, the core write enable.
REQ-009 SHALL have port data_memory_data, output, 32, the read data returned to the core.
REQ-010 SHALL have port tx_data, output, 8, the FIFO head byte.
REQ-011 SHALL have port tx_valid, output, 1, asserted when the FIFO is non-empty.
REQ-012 SHALL have port tx_ready, input, 1, the consumer accept signal.
REQ-013 SHALL have port timer_irq, output, 1, the timer-expired level.

Function
REQ-014 SHALL decode addr[31:16]==0x0000 as RAM, word index addr[11:2], with the upper bits ignored.
REQ-015 SHALL decode addr[31:16]==0x0001 as registers: 0x00 CYCLE (RO), 0x04 TX_DATA (WO), 0x08 TX_STATUS, 0x0C TIMER_CMP (RW), 0x10 TIMER_STAT.
REQ-016 SHALL read as 0 for any unmapped address or WO register; writes to unmapped or RO addresses SHALL have no effect.
REQ-017 SHALL return data_memory_data combinationally, in the same cycle as the address, with zero wait states.
REQ-018 SHALL write RAM and registers on the rising clk edge where data_memory_we=1; a read of the same address in that cycle SHALL return the old value.
REQ-019 SHALL increment CYCLE by 1 every cycle and wrap 0xFFFF_FFFF->0.
REQ-020 SHALL, when TIMER_CMP!=0 and CYCLE==TIMER_CMP, set the sticky TIMER_STAT[0] on the next edge; timer_irq SHALL equal TIMER_STAT[0].
REQ-021 SHALL clear TIMER_STAT[0] on a write with wd[0]=1 (write-one-to-clear); a simultaneous set and clear SHALL leave it set.
REQ-022 SHALL push wd[7:0] to the FIFO on a write to TX_DATA when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-023 SHALL drop a push to a full FIFO with no pop, leave its contents unchanged, and set sticky TX_STATUS[2] (overflow), cleared by a TX_STATUS write with wd[2]=1.
REQ-024 SHALL assert tx_valid = !empty and drive tx_data = head byte; a pop SHALL occur on the edge where tx_valid && tx_ready.
REQ-025 SHALL report TX_STATUS as bit0 full, bit1 empty, bit2 overflow, bits[7:4] count (0..TX_DEPTH), and other bits 0.
REQ-026 SHALL ignore a push and pop in the same cycle when empty for the pop; the pushed byte appears on tx_data the next cycle.
REQ-027 SHALL wrap FIFO pointers modulo TX_DEPTH; count SHALL never exceed TX_DEPTH or go below 0.

Reset
REQ-028 SHALL, while reset_n=0, force CYCLE=0, TIMER_CMP=0, TIMER_STAT=0, FIFO empty (count 0), overflow=0, tx_valid=0, tx_data=0, timer_irq=0.
REQ-029 SHALL leave RAM contents unchanged on reset.
REQ-030 SHALL, when reset is asserted mid-transfer, discard FIFO contents immediately and not pop the pending head.

Structure
REQ-031 SHALL place the region bases, register offsets and TX_STATUS bit positions in a shared package data_bus_pkg.
REQ-032 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-033 SHALL cover: write 0xDEADBEEF @0x0000_0010, read same -> 0xDEADBEEF; read @0x0000_1010 (aliased) -> 0xDEADBEEF.
REQ-034 SHALL cover: release reset, read CYCLE at cycle N -> N (±0 fixed offset); force CYCLE 0xFFFF_FFFF -> next read 0.
REQ-035 SHALL cover: TIMER_CMP=100 -> timer_irq rises the cycle after CYCLE==100; write TIMER_STAT=1 -> irq low next cycle.
REQ-036 SHALL cover: tx_ready=0, push 9 bytes 0x01..0x09 -> TX_STATUS=0x81|0x04 (full, count 8, overflow), tx_data=0x01; then tx_ready=1 -> bytes 0x01..0x08 in order, then empty.
REQ-037 SHALL cover: FIFO full plus push 0xAA with a simultaneous pop -> count stays 8, overflow stays 0, 0xAA emitted last.
REQ-038 SHALL cover: reset_n low with 3 bytes queued -> tx_valid=0 asynchronously; a RAM word written before reset is still readable after reset.

Source files
------------

// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - address map, register offsets and TX_STATUS layout for the MMIO data bus
package data_bus_pkg;

   localparam logic [15:0] RAM_REGION     = 16'h0000;
   localparam logic [15:0] REG_REGION     = 16'h0001;

   localparam logic [15:0] OFF_CYCLE      = 16'h0000;
   localparam logic [15:0] OFF_TX_DATA    = 16'h0004;
   localparam logic [15:0] OFF_TX_STATUS  = 16'h0008;
   localparam logic [15:0] OFF_TIMER_CMP  = 16'h000C;
   localparam logic [15:0] OFF_TIMER_STAT = 16'h0010;

   localparam int TXS_FULL_BIT  = 0;
   localparam int TXS_EMPTY_BIT = 1;
   localparam int TXS_OVF_BIT   = 2;
   localparam int TXS_COUNT_LSB = 4;
   localparam int TXS_COUNT_W   = 4;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_CYCLE,
      SEL_TX_DATA,
      SEL_TX_STATUS,
      SEL_TIMER_CMP,
      SEL_TIMER_STAT
   } sel_e;

   // Upper half picks the region; inside the register region only exact offsets hit.
   function automatic sel_e decode(input logic [31:0] addr);
      sel_e s;
      s = SEL_NONE;
      if (addr[31:16] == RAM_REGION) begin
         s = SEL_RAM;
      end else if (addr[31:16] == REG_REGION) begin
         case (addr[15:0])
            OFF_CYCLE:      s = SEL_CYCLE;
            OFF_TX_DATA:    s = SEL_TX_DATA;
            OFF_TX_STATUS:  s = SEL_TX_STATUS;
            OFF_TIMER_CMP:  s = SEL_TIMER_CMP;
            OFF_TIMER_STAT: s = SEL_TIMER_STAT;
            default:        s = SEL_NONE;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/data_bus_mmio_sync_fifo.sv
// rtl/data_bus_mmio_sync_fifo.sv - single-clock FIFO; DEPTH must be a power of two
module sync_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 8,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic             push_ok
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign pop_ok  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/data_bus_mmio.sv
// rtl/data_bus_mmio.sv - zero-wait-state data RAM plus cycle counter, timer and TX byte FIFO registers
module data_bus_mmio
   import data_bus_pkg::*;
#(
   parameter int RAM_WORDS = 1024,
   parameter int TX_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] data_memory_addr,
   input  logic [31:0] data_memory_wd,
   input  logic        data_memory_we,
   output logic [31:0] data_memory_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int CW = $clog2(TX_DEPTH + 1);

   sel_e          sel;
   logic [AW-1:0] ram_idx;
   logic [31:0]   ram_q [RAM_WORDS];

   logic [31:0]   cycle_q, cycle_d;
   logic [31:0]   timer_cmp_q, timer_cmp_d;
   logic          timer_stat_q, timer_stat_d;
   logic          ovf_q, ovf_d;

   logic          fifo_push, fifo_push_ok, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]    fifo_head;
   logic [31:0]   tx_status;

   assign sel       = decode(data_memory_addr);
   assign ram_idx   = data_memory_addr[AW+1:2];
   assign fifo_push = data_memory_we && (sel == SEL_TX_DATA);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .rst_n     (reset_n),
      .push      (fifo_push),
      .push_data (data_memory_wd[7:0]),
      .pop       (tx_ready),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .push_ok   (fifo_push_ok)
   );

   always_comb begin
      tx_status                                  = '0;
      tx_status[TXS_FULL_BIT]                    = fifo_full;
      tx_status[TXS_EMPTY_BIT]                   = fifo_empty;
      tx_status[TXS_OVF_BIT]                     = ovf_q;
      tx_status[TXS_COUNT_LSB +: TXS_COUNT_W]    = TXS_COUNT_W'(fifo_count);
   end

   always_comb begin
      data_memory_data = '0;
      case (sel)
         SEL_RAM:        data_memory_data = ram_q[ram_idx];
         SEL_CYCLE:      data_memory_data = cycle_q;
         SEL_TX_STATUS:  data_memory_data = tx_status;
         SEL_TIMER_CMP:  data_memory_data = timer_cmp_q;
         SEL_TIMER_STAT: data_memory_data = {31'b0, timer_stat_q};
         default:        data_memory_data = '0;
      endcase
   end

   // Set terms are applied after clear terms so a coincident set wins.
   always_comb begin
      cycle_d      = cycle_q + 32'd1;
      timer_cmp_d  = timer_cmp_q;
      timer_stat_d = timer_stat_q;
      ovf_d        = ovf_q;
      if (data_memory_we && (sel == SEL_TIMER_CMP)) timer_cmp_d = data_memory_wd;
      if (data_memory_we && (sel == SEL_TIMER_STAT) && data_memory_wd[0]) timer_stat_d = 1'b0;
      if ((timer_cmp_q != '0) && (cycle_q == timer_cmp_q)) timer_stat_d = 1'b1;
      if (data_memory_we && (sel == SEL_TX_STATUS) && data_memory_wd[TXS_OVF_BIT]) ovf_d = 1'b0;
      if (fifo_push && !fifo_push_ok) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_q      <= '0;
         timer_cmp_q  <= '0;
         timer_stat_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         cycle_q      <= cycle_d;
         timer_cmp_q  <= timer_cmp_d;
         timer_stat_q <= timer_stat_d;
         ovf_q        <= ovf_d;
      end
   end

   // RAM keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (data_memory_we && (sel == SEL_RAM)) ram_q[ram_idx] <= data_memory_wd;
   end

   assign tx_valid  = !fifo_empty;
   assign tx_data   = fifo_head;
   assign timer_irq = timer_stat_q;

endmodule

// File: tb/tb_data_bus_mmio.sv
// tb/tb_data_bus_mmio.sv - directed table and sequence bench for data_bus_mmio
module tb_data_bus_mmio;

   localparam logic [31:0] A_CYC  = 32'h0001_0000;
   localparam logic [31:0] A_TXD  = 32'h0001_0004;
   localparam logic [31:0] A_TXS  = 32'h0001_0008;
   localparam logic [31:0] A_TCMP = 32'h0001_000C;
   localparam logic [31:0] A_TST  = 32'h0001_0010;

   logic        clk;
   logic        reset_n;
   logic [31:0] data_memory_addr;
   logic [31:0] data_memory_wd;
   logic        data_memory_we;
   logic [31:0] data_memory_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        timer_irq;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wd;
      logic        we;
      logic        chk;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   data_bus_mmio #(
      .RAM_WORDS (1024),
      .TX_DEPTH  (8)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .data_memory_addr (data_memory_addr),
      .data_memory_wd   (data_memory_wd),
      .data_memory_we   (data_memory_we),
      .data_memory_data (data_memory_data),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .timer_irq        (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
      @(negedge clk);
      data_memory_addr = a;
      data_memory_wd   = d;
      data_memory_we   = w;
      tx_ready         = r;
      #1;
   endtask

   initial begin
      logic [7:0] exp_b;
      bit         found;

      reset_n          = 1'b0;
      data_memory_addr = A_TXS;
      data_memory_wd   = '0;
      data_memory_we   = 1'b0;
      tx_ready         = 1'b0;

      vecs.push_back('{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         "ram_wr_10"});
      vecs.push_back('{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, "ram_rd_10"});
      vecs.push_back('{32'h0000_1010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, "ram_alias_1010"});
      vecs.push_back('{32'h0002_0010, 32'h0,         1'b0, 1'b1, 32'h0,         "unmapped_region_rd"});
      vecs.push_back('{32'h0000_0010, 32'h1234_5678, 1'b1, 1'b1, 32'hDEAD_BEEF, "ram_wr_reads_old"});
      vecs.push_back('{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h1234_5678, "ram_rd_new"});
      vecs.push_back('{32'h0000_0FFC, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0,         "ram_wr_top"});
      vecs.push_back('{32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5, "ram_rd_top"});
      vecs.push_back('{32'h0000_FFFC, 32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5, "ram_alias_fffc"});
      vecs.push_back('{A_TCMP,        32'hFFFF_0000, 1'b1, 1'b1, 32'h0,         "tcmp_wr_reads_old"});
      vecs.push_back('{A_TCMP,        32'h0,         1'b0, 1'b1, 32'hFFFF_0000, "tcmp_rd"});
      vecs.push_back('{A_TXD,         32'h0,         1'b0, 1'b1, 32'h0,         "txdata_wo_reads_0"});
      vecs.push_back('{A_TXS,         32'h0,         1'b0, 1'b1, 32'h0000_0002, "txstatus_empty"});
      vecs.push_back('{A_TST,         32'h0,         1'b0, 1'b1, 32'h0,         "tstat_idle"});
      vecs.push_back('{32'h0002_0010, 32'h1111_1111, 1'b1, 1'b1, 32'h0,         "unmapped_wr"});
      vecs.push_back('{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h1234_5678, "unmapped_wr_no_effect"});
      vecs.push_back('{32'h0001_0014, 32'h0,         1'b0, 1'b1, 32'h0,         "unmapped_reg_rd"});
      vecs.push_back('{A_TCMP,        32'h0,         1'b1, 1'b1, 32'hFFFF_0000, "tcmp_restore"});
      vecs.push_back('{A_TCMP,        32'h0,         1'b0, 1'b1, 32'h0,         "tcmp_zero"});

      repeat (3) @(negedge clk);
      #1;
      check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      check("rst_tx_data", {24'b0, tx_data}, 32'h0);
      check("rst_timer_irq", {31'b0, timer_irq}, 32'h0);
      check("rst_txstatus", data_memory_data, 32'h0000_0002);
      data_memory_addr = A_CYC;
      #1;
      check("rst_cycle", data_memory_data, 32'h0);

      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("cycle_at_0", data_memory_data, 32'h0);
      for (int i = 1; i <= 5; i++) begin
         bus(A_CYC, 32'h0, 1'b0, 1'b0);
         check("cycle_at_n", data_memory_data, 32'(i));
      end

      foreach (vecs[i]) begin
         bus(vecs[i].addr, vecs[i].wd, vecs[i].we, 1'b0);
         if (vecs[i].chk) check(vecs[i].name, data_memory_data, vecs[i].exp);
      end

      bus(A_TCMP, 32'd100, 1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         bus(A_CYC, 32'h0, 1'b0, 1'b0);
         if (data_memory_data == 32'd100) begin
            found = 1'b1;
            break;
         end
      end
      check("timer_reached_100", {31'b0, found}, 32'h1);
      check("irq_low_at_match", {31'b0, timer_irq}, 32'h0);
      bus(A_TST, 32'h0, 1'b0, 1'b0);
      check("irq_high_after_match", {31'b0, timer_irq}, 32'h1);
      check("tstat_set", data_memory_data, 32'h1);
      bus(A_TST, 32'h1, 1'b1, 1'b0);
      check("irq_held_until_edge", {31'b0, timer_irq}, 32'h1);
      bus(A_TST, 32'h0, 1'b0, 1'b0);
      check("irq_cleared", {31'b0, timer_irq}, 32'h0);
      bus(A_TCMP, 32'h0, 1'b1, 1'b0);

      @(negedge clk);
      data_memory_addr = A_CYC;
      data_memory_we   = 1'b0;
      force dut.cycle_q = 32'hFFFF_FFFF;
      #1;
      check("cycle_max", data_memory_data, 32'hFFFF_FFFF);
      release dut.cycle_q;
      bus(A_CYC, 32'h0, 1'b0, 1'b0);
      check("cycle_wrap", data_memory_data, 32'h0);

      for (int i = 1; i <= 9; i++) bus(A_TXD, 32'(i), 1'b1, 1'b0);
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("fifo_full_ovf_status", data_memory_data, 32'h0000_0085);
      check("fifo_head_01", {24'b0, tx_data}, 32'h01);
      check("fifo_valid_full", {31'b0, tx_valid}, 32'h1);
      for (int i = 1; i <= 8; i++) begin
         bus(A_TXS, 32'h0, 1'b0, 1'b1);
         check("fifo_drain_order", {24'b0, tx_data}, 32'(i));
      end
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("fifo_drained_valid", {31'b0, tx_valid}, 32'h0);
      check("fifo_drained_status", data_memory_data, 32'h0000_0006);
      bus(A_TXS, 32'h4, 1'b1, 1'b0);
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("ovf_cleared", data_memory_data, 32'h0000_0002);

      for (int i = 0; i < 8; i++) bus(A_TXD, 32'h11 + 32'(i), 1'b1, 1'b0);
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("fifo_full_no_ovf", data_memory_data, 32'h0000_0081);
      bus(A_TXD, 32'hAA, 1'b1, 1'b1);
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("full_push_pop_status", data_memory_data, 32'h0000_0081);
      for (int j = 0; j < 8; j++) begin
         exp_b = (j < 7) ? 8'(8'h12 + j) : 8'hAA;
         bus(A_TXS, 32'h0, 1'b0, 1'b1);
         check("full_push_pop_order", {24'b0, tx_data}, {24'b0, exp_b});
      end
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("full_push_pop_empty", {31'b0, tx_valid}, 32'h0);

      bus(A_TXD, 32'h5C, 1'b1, 1'b1);
      check("empty_push_pop_valid0", {31'b0, tx_valid}, 32'h0);
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("empty_push_pop_head", {24'b0, tx_data}, 32'h5C);
      check("empty_push_pop_status", data_memory_data, 32'h0000_0010);
      bus(A_TXS, 32'h0, 1'b0, 1'b1);
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("single_popped", {31'b0, tx_valid}, 32'h0);

      for (int i = 0; i < 3; i++) bus(A_TXD, 32'h31 + 32'(i), 1'b1, 1'b0);
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("three_queued", data_memory_data, 32'h0000_0030);
      @(posedge clk);
      #2;
      reset_n  = 1'b0;
      tx_ready = 1'b1;
      #1;
      check("async_rst_valid", {31'b0, tx_valid}, 32'h0);
      check("async_rst_data", {24'b0, tx_data}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n          = 1'b1;
      tx_ready         = 1'b0;
      data_memory_addr = 32'h0000_0010;
      data_memory_we   = 1'b0;
      #1;
      check("ram_survives_reset", data_memory_data, 32'h1234_5678);
      bus(A_TXS, 32'h0, 1'b0, 1'b0);
      check("fifo_empty_after_reset", data_memory_data, 32'h0000_0002);
      check("valid_low_after_reset", {31'b0, tx_valid}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
